call_dispatch: RTL and testbench
================================

# call_dispatch

Upstream sequencer for a start/done function unit (the `clk, reset, start, a, b, result, done` callee produced by our flow). Accepts operand pairs on a valid/ready stream, buffers them in a small FIFO, and issues one call at a time to the callee. It drives `start` and holds `a`/`b` stable, then waits for the rising edge of `done`. It returns each `result` on a valid/ready output stream in issue order.

## Interface
Parameters:
- `WIDTH`, default 32: operand and result width.
- `DEPTH`, default 4: input FIFO entries; must be a power of 2, minimum 2.
- `TIMEOUT`, default 255: cycles allowed in WAIT before abort. Used only with `CALL_DISPATCH_TIMEOUT_EN`.

Ports:
- `clk`, in, 1: sole clock, rising edge.
- `reset`, in, 1: asynchronous, active-high reset.
- `in_valid`, in, 1: operand pair offered.
- `in_ready`, out, 1: equals `!fifo_full`.
- `in_a`, in, WIDTH: first operand.
- `in_b`, in, WIDTH: second operand.
- `callee_start`, out, 1: one-cycle call request.
- `callee_a`, out, WIDTH: held operand to callee.
- `callee_b`, out, WIDTH: held operand to callee.
- `callee_result`, in, WIDTH: callee result.
- `callee_done`, in, 1: callee completion level.
- `out_valid`, out, 1: result available.
- `out_ready`, in, 1: consumer accepts the result.
- `out_result`, out, WIDTH: returned value.
- `out_err`, out, 1: result aborted by timeout. Constant 0 without the macro.
- `busy`, out, 1: FSM not in IDLE.
- `call_count`, out, 16: completed calls, including aborted ones. Wraps at 0xFFFF→0.

## Operation
- FIFO push when `in_valid && in_ready`. Pop happens only in the IDLE→ISSUE transition. A push and a pop in the same cycle leave the count unchanged.
- `done_q` registers `callee_done` every cycle. A rising edge is defined as `callee_done && !done_q`.
- FSM states:
  - IDLE: if FIFO is non-empty, pop the head into `callee_a`/`callee_b` and go to ISSUE.
  - ISSUE: `callee_start`=1 for exactly this cycle, then go to WAIT.
  - WAIT: `callee_a`/`callee_b` held. On a rising edge of done, capture `callee_result` into `out_result` and go to OUTPUT.
  - OUTPUT: `out_valid`=1, `out_result` held. On `out_ready`, increment `call_count` and go to IDLE.
- Operand and result registers are loaded only on the transitions above. Outputs are stable otherwise.
- A stale `callee_done` that is high when WAIT is entered is ignored until it falls and rises again.
- Rising edges of done seen outside WAIT are ignored.
- `in_ready` is independent of FSM state. The FIFO keeps accepting while a call is in flight.
- Reset values: `in_ready`=1, `callee_start`=0, `callee_a`=0, `callee_b`=0, `out_valid`=0, `out_result`=0, `out_err`=0, `busy`=0, `call_count`=0. FIFO is empty, `done_q`=0, FSM is in IDLE.
- Reset asserted mid-call discards FIFO contents and any in-flight call immediately. The callee must be reset in the same window; the system guarantees this.

## Timing
- Push at edge t0 → IDLE pops at edge t1 → `callee_start` high during cycle t2.
- Against the standard callee, done rises in cycle t5 and `out_valid` rises in cycle t6.
- Input-to-output latency is therefore 6 cycles with an idle FSM. Repeat calls are back-to-back limited: minimum of 5 cycles per call plus 1 cycle for the OUTPUT handshake.
- `out_valid` is asserted from the cycle after the done edge until the cycle `out_ready` is sampled high. Earliest next `callee_start` is 2 cycles after acceptance.
- No combinational path exists from `callee_*` inputs to outputs. `in_ready` depends only on registered count.

## Configuration
- `CALL_DISPATCH_TIMEOUT_EN` defined:
  - A cycle counter clears on entry to WAIT.
  - If it reaches `TIMEOUT` without a rising edge of done, go to OUTPUT with `out_result`=0 and `out_err`=1.
  - `out_err` clears when the result is accepted.
- Undefined: no counter, `out_err` tied 0, WAIT waits indefinitely.

## Test plan
- Single call: push a=0x12, b=0x34 with a standard callee → `callee_start` pulse in cycle t2; `out_valid` in t6 with `out_result`=0x12; `call_count`=1 after accept.
- Full FIFO: hold `out_ready`=0 and push 6 pairs with DEPTH=4 → `in_ready` falls after 5 accepted (4 queued plus 1 in flight). Release → 5 results in push order.
- Stale done: callee model holds `callee_done`=1 into ISSUE and drops it for 1 cycle before re-raising → exactly one capture, on the re-rise.
- Backpressure: `out_ready` low for 10 cycles in OUTPUT → `out_result` stable and no new `callee_start`.
- Reset mid-WAIT: assert `reset` asynchronously between clock edges → all outputs reach their reset values before the next edge; FIFO empty.
- Macro on, TIMEOUT=8, callee never raises done → `out_valid` with `out_err`=1 and `out_result`=0 after 8 WAIT cycles; the next call proceeds normally.

Source files
------------

// File: rtl/call_dispatch.sv
// call_dispatch: queues operand pairs and runs them one at a time through a start/done callee.
// Define CALL_DISPATCH_TIMEOUT_EN to abort a call after TIMEOUT cycles without a done edge.
module call_dispatch #(
    parameter int WIDTH   = 32,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             callee_start,
    output logic [WIDTH-1:0] callee_a,
    output logic [WIDTH-1:0] callee_b,
    input  logic [WIDTH-1:0] callee_result,
    input  logic             callee_done,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_err,
    output logic             busy,
    output logic [15:0]      call_count
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_OUTPUT} state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] mem_a [DEPTH];
    logic [WIDTH-1:0] mem_b [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      count;
    logic             push, pop, capture, accept, abort;
    logic             done_q, done_rise;

    assign in_ready     = (count != (AW+1)'(DEPTH));
    assign push         = in_valid && in_ready;
    assign done_rise    = callee_done && !done_q;
    assign callee_start = (state == S_ISSUE);
    assign out_valid    = (state == S_OUTPUT);
    assign busy         = (state != S_IDLE);

    // Storage needs no reset; count and pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_a[wr_ptr] <= in_a;
            mem_b[wr_ptr] <= in_b;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)
                count <= count + 1'b1;
            else if (pop && !push)
                count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= S_IDLE;
            done_q <= 1'b0;
        end else begin
            state  <= state_next;
            done_q <= callee_done;
        end
    end

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        capture    = 1'b0;
        accept     = 1'b0;
        case (state)
            S_IDLE: begin
                if (count != '0) begin
                    pop        = 1'b1;
                    state_next = S_ISSUE;
                end
            end
            S_ISSUE: state_next = S_WAIT;
            S_WAIT: begin
                if (done_rise) begin
                    capture    = 1'b1;
                    state_next = S_OUTPUT;
                end else if (abort) begin
                    state_next = S_OUTPUT;
                end
            end
            S_OUTPUT: begin
                if (out_ready) begin
                    accept     = 1'b1;
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            callee_a   <= '0;
            callee_b   <= '0;
            out_result <= '0;
            call_count <= '0;
        end else begin
            if (pop) begin
                callee_a <= mem_a[rd_ptr];
                callee_b <= mem_b[rd_ptr];
            end
            if (capture)
                out_result <= callee_result;
            else if (abort)
                out_result <= '0;
            if (accept)
                call_count <= call_count + 16'd1;
        end
    end

`ifdef CALL_DISPATCH_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] timer;
    logic          err_q;

    // A done edge in the final allowed cycle still wins over the abort.
    assign abort   = (state == S_WAIT) && !done_rise && (timer == TW'(TIMEOUT - 1));
    assign out_err = err_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timer <= '0;
            err_q <= 1'b0;
        end else begin
            if (state == S_ISSUE)
                timer <= '0;
            else if (state == S_WAIT)
                timer <= timer + 1'b1;
            if (abort)
                err_q <= 1'b1;
            else if (accept)
                err_q <= 1'b0;
        end
    end
`else
    // Keeps TIMEOUT referenced when the abort path is compiled out.
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT != 0);
    assign abort          = 1'b0;
    assign out_err        = 1'b0;
`endif

endmodule

// File: tb/tb_call_dispatch.sv
// tb_call_dispatch: scoreboard bench for call_dispatch with a behavioural start/done callee.
// Runs the abort scenario too when CALL_DISPATCH_TIMEOUT_EN is defined.
module tb_call_dispatch;

    localparam int WIDTH   = 32;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a, in_b;
    logic             callee_start;
    logic [WIDTH-1:0] callee_a, callee_b;
    logic [WIDTH-1:0] callee_result;
    logic             callee_done;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic             out_err;
    logic             busy;
    logic [15:0]      call_count;

    int total = 0;
    int bad   = 0;

    logic [WIDTH:0]     exp_q[$];
    logic [2*WIDTH-1:0] issue_q[$];
    logic [WIDTH:0]     res_ent;
    logic [2*WIDTH-1:0] iss_ent;
    int                 start_seen = 0;
    int                 expected_calls = 0;

    int               callee_lat;
    logic             stale_mode, never_done, extra_done;
    logic             m_done, m_active;
    int               m_cnt;
    logic [WIDTH-1:0] m_res, m_pend;

    always #5 clk = ~clk;

    assign callee_done   = m_done | extra_done;
    assign callee_result = m_res;

    call_dispatch #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .callee_start(callee_start), .callee_a(callee_a), .callee_b(callee_b),
        .callee_result(callee_result), .callee_done(callee_done),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_err(out_err), .busy(busy), .call_count(call_count)
    );

    // Callee: result = a; done is a level held until the next start. Stale mode keeps
    // done high past the start, drops it one cycle, then raises it with the new result.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_done <= 1'b0; m_active <= 1'b0; m_cnt <= 0; m_res <= '0; m_pend <= '0;
        end else if (callee_start) begin
            m_done   <= stale_mode ? m_done : 1'b0;
            m_pend   <= callee_a;
            m_cnt    <= callee_lat;
            m_active <= !never_done;
        end else if (m_active) begin
            if (m_cnt == 2 && stale_mode)
                m_done <= 1'b0;
            if (m_cnt == 1) begin
                m_done   <= 1'b1;
                m_res    <= m_pend;
                m_active <= 1'b0;
            end
            m_cnt <= m_cnt - 1;
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Issue order and returned results are both checked against the queues.
    always @(negedge clk) begin
        if (!reset) begin
            if (callee_start) begin
                start_seen++;
                if (issue_q.size() == 0)
                    checkOutput("unexpected_start", 1, 0);
                else begin
                    iss_ent = issue_q.pop_front();
                    checkOutput("issue_a", callee_a, iss_ent[2*WIDTH-1:WIDTH]);
                    checkOutput("issue_b", callee_b, iss_ent[WIDTH-1:0]);
                end
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0)
                    checkOutput("unexpected_result", 1, 0);
                else begin
                    res_ent = exp_q.pop_front();
                    checkOutput("result", out_result, res_ent[WIDTH-1:0]);
                    checkOutput("result_err", out_err, res_ent[WIDTH]);
                end
            end
        end
    end

    task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic [WIDTH-1:0] res, input logic err);
        int tries = 0;
        in_valid = 1'b1; in_a = a; in_b = b;
        while (!in_ready && tries < 100) begin
            @(posedge clk); #1; tries++;
        end
        if (!in_ready)
            checkOutput("push_timeout", 0, 1);
        else begin
            issue_q.push_back({a, b});
            exp_q.push_back({err, res});
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic waitIdle(input int bound);
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < bound) begin
            @(posedge clk); #1; n++;
        end
        if (n >= bound)
            checkOutput("drain_timeout", 1, 0);
    endtask

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: got stuck expected finish");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int accepted, n, s0;
        logic last_ready, changed, seen;
        logic [WIDTH-1:0] held;

        reset = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b1;
        callee_lat = 2; stale_mode = 1'b0; never_done = 1'b0; extra_done = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_in_ready", in_ready, 1);
        checkOutput("rst_start", callee_start, 0);
        checkOutput("rst_valid", out_valid, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_count", call_count, 0);
        checkOutput("rst_err", out_err, 0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Single call with cycle-exact timing from the push edge.
        in_valid = 1'b1; in_a = 32'h12; in_b = 32'h34;
        issue_q.push_back({32'h12, 32'h34});
        exp_q.push_back({1'b0, 32'h12});
        checkOutput("t1_in_ready", in_ready, 1);
        for (int c = 0; c <= 6; c++) begin
            @(posedge clk); #1;
            if (c == 0) in_valid = 1'b0;
            if (c == 1) checkOutput("t1_start_t2", callee_start, 1);
            if (c == 2) checkOutput("t1_start_one_cycle", callee_start, 0);
            if (c == 4) checkOutput("t1_valid_early", out_valid, 0);
            if (c == 5) begin
                checkOutput("t1_valid_t6", out_valid, 1);
                checkOutput("t1_result", out_result, 32'h12);
            end
        end
        expected_calls = 1;
        checkOutput("t1_count", call_count, 16'(expected_calls));

        // Fill the FIFO while the consumer stalls, then hold the output.
        out_ready = 1'b0; accepted = 0; last_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1; in_a = 32'h100 + i; in_b = 32'h200 + i;
            last_ready = in_ready;
            if (in_ready) begin
                accepted++;
                issue_q.push_back({in_a, in_b});
                exp_q.push_back({1'b0, in_a});
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        checkOutput("full_accepted", accepted, 5);
        checkOutput("full_sixth_refused", last_ready, 0);
        n = 0;
        while (!out_valid && n < 50) begin @(posedge clk); #1; n++; end
        checkOutput("bp_valid", out_valid, 1);
        held = out_result; s0 = start_seen; changed = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
            if (out_result !== held || !out_valid) changed = 1'b1;
        end
        checkOutput("bp_stable", changed, 0);
        checkOutput("bp_nostart", start_seen - s0, 0);
        checkOutput("bp_first_result", held, 32'h100);
        checkOutput("bp_in_ready", in_ready, 0);
        out_ready = 1'b1;
        waitIdle(300);
        expected_calls += 5;
        checkOutput("full_count", call_count, 16'(expected_calls));

        // Done still high from the last call; only the re-rise may be captured.
        stale_mode = 1'b1; callee_lat = 3;
        applyStimulus(32'h55, 32'h66, 32'h55, 1'b0);
        waitIdle(100);
        expected_calls += 1;
        checkOutput("stale_count", call_count, 16'(expected_calls));
        stale_mode = 1'b0; callee_lat = 2;

        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    logic [WIDTH-1:0] r;
                    r = $urandom;
                    applyStimulus(r, r ^ 32'hFFFF, r, 1'b0);
                end
            end
            begin
                repeat (60) begin
                    @(posedge clk); #1;
                    out_ready = ($urandom_range(0, 1) == 1);
                end
            end
        join
        out_ready = 1'b1;
        waitIdle(300);
        expected_calls += 6;
        checkOutput("burst_count", call_count, 16'(expected_calls));

        // Reset between edges while a call sits in WAIT with more queued behind it.
        applyStimulus(32'h31, 32'h41, 32'h31, 1'b0);
        applyStimulus(32'h32, 32'h42, 32'h32, 1'b0);
        applyStimulus(32'h33, 32'h43, 32'h33, 1'b0);
        #2;
        reset = 1'b1;
        exp_q.delete(); issue_q.delete();
        #1;
        checkOutput("mid_rst_in_ready", in_ready, 1);
        checkOutput("mid_rst_start", callee_start, 0);
        checkOutput("mid_rst_a", callee_a, 0);
        checkOutput("mid_rst_b", callee_b, 0);
        checkOutput("mid_rst_busy", busy, 0);
        checkOutput("mid_rst_valid", out_valid, 0);
        checkOutput("mid_rst_result", out_result, 0);
        checkOutput("mid_rst_err", out_err, 0);
        checkOutput("mid_rst_count", call_count, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        expected_calls = 0;
        seen = 1'b0;
        extra_done = 1'b1;
        @(posedge clk); #1;
        extra_done = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
            if (busy || out_valid) seen = 1'b1;
        end
        checkOutput("post_rst_idle", seen, 0);
        applyStimulus(32'h5A, 32'hA5, 32'h5A, 1'b0);
        waitIdle(100);
        expected_calls += 1;
        checkOutput("post_rst_count", call_count, 16'(expected_calls));

`ifdef CALL_DISPATCH_TIMEOUT_EN
        never_done = 1'b1; out_ready = 1'b0;
        applyStimulus(32'hAA, 32'hBB, 32'h0, 1'b1);
        @(posedge clk); #1;
        checkOutput("to_start", callee_start, 1);
        for (int w = 0; w <= 8; w++) begin
            @(posedge clk); #1;
            if (w == 7) checkOutput("to_valid_early", out_valid, 0);
            if (w == 8) begin
                checkOutput("to_valid", out_valid, 1);
                checkOutput("to_err", out_err, 1);
                checkOutput("to_result", out_result, 0);
            end
        end
        out_ready = 1'b1;
        waitIdle(50);
        checkOutput("to_err_cleared", out_err, 0);
        never_done = 1'b0;
        applyStimulus(32'h77, 32'h88, 32'h77, 1'b0);
        waitIdle(100);
        expected_calls += 2;
        checkOutput("to_count", call_count, 16'(expected_calls));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
